// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared encodings for the reset sequencer.
//   RC_*   : reset-cause codes reported on rst_cause
//   states : FSM state codes used by reset_seq
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  // Reset cause encodings (value 3 is reserved).
  localparam logic [1:0] RC_POR  = 2'd0;
  localparam logic [1:0] RC_LOCK = 2'd1;
  localparam logic [1:0] RC_BTN  = 2'd2;

  // FSM state encodings.
  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

endpackage

// File: rtl/reset_seq_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes the raw active-low user button into clk, debounces it and
// produces a one-cycle pulse on each debounced press.
// Ports:
//   clk     in  core clock
//   resetn  in  asynchronous active-low reset
//   btn_n   in  raw button, low = pressed, asynchronous to clk
//   btn_db  out debounced level, 1 = pressed
//   press   out single-cycle pulse, aligned with btn_db rising 0->1
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 640000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic btn_db,
  output logic press
);

  localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DCNT_W-1:0]      cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   press_q, press_d;

  // Plain shift chain; preset to 1 so reset looks like a released button.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synchronized pin disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    if (~btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DCNT_LAST) begin
      cnt_d   = '0;
      db_d    = ~db_q;
      press_d = ~db_q;
    end else begin
      cnt_d = cnt_q + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign btn_db = db_q;
  assign press  = press_q;

endmodule

// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq
// Combines PLL lock and the user button into a clean active-high core reset
// (asynchronous assert via resetn, synchronous release after a hold time),
// and records the cause of the last reset plus a saturating reset count.
// Ports:
//   clk        in  core clock (PLL output)
//   resetn     in  asynchronous active-low power-on reset
//   btn_n      in  raw user button, low = pressed, asynchronous
//   locked     in  PLL lock, asynchronous
//   reset      out registered active-high core reset
//   btn_db     out debounced button level, 1 = pressed
//   rst_cause  out cause of last reset (POR / LOCK / BTN)
//   rst_count  out resets since POR, saturating
// ---------------------------------------------------------------------------
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 640000,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn_n,
  input  logic             locked,
  output logic             reset,
  output logic             btn_db,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] rst_count
);

  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   btn_db_w;
  logic                   press;

  logic [1:0]        state_q, state_d;
  logic [HCNT_W-1:0] hold_q, hold_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_inc;
  logic              reset_q;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .resetn (resetn),
    .btn_n  (btn_n),
    .btn_db (btn_db_w),
    .press  (press)
  );

  // Lock synchronizer, cleared so reset starts from "not locked".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    count_d = count_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (btn_db_w) begin
          // A held button keeps the core in reset.
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - HCNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous press.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cause_d = RC_LOCK;
          count_d = count_inc;
        end else if (press) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = RC_BTN;
          count_d = count_inc;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // reset is registered from the next state so it tracks state_q exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
      cause_q <= RC_POR;
      count_q <= '0;
      reset_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
      count_q <= count_d;
      reset_q <= (state_d != RUN);
    end
  end

  assign reset     = reset_q;
  assign btn_db    = btn_db_w;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_reset_seq
// Directed self-checking bench for reset_seq with DEB_CYCLES=4,
// HOLD_CYCLES=8, SYNC_STAGES=2, CNT_W=8. Inputs are driven and outputs
// sampled 1 time unit after each rising clk edge.
// ---------------------------------------------------------------------------
module tb_reset_seq;

  logic       clk;
  logic       resetn;
  logic       btn_n;
  logic       locked;
  logic       reset;
  logic       btn_db;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int n_checks;
  int n_fail;
  int exp_count;

  reset_seq #(
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (8),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_n     (btn_n),
    .locked    (locked),
    .reset     (reset),
    .btn_db    (btn_db),
    .rst_cause (rst_cause),
    .rst_count (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // POR release with locked already high: reset falls on the 11th edge.
  task automatic test_reset();
    resetn = 1'b0;
    btn_n  = 1'b1;
    locked = 1'b1;
    #12;
    n_checks++;
    if (reset !== 1'b1 || btn_db !== 1'b0 || rst_cause !== 2'd0 || rst_count !== 8'd0) begin
      n_fail++;
      $display("FAIL por_state: reset=%b btn_db=%b cause=%0d count=%0d, expected 1 0 0 0",
               reset, btn_db, rst_cause, rst_count);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(10);
    n_checks++;
    if (reset !== 1'b1) begin
      n_fail++;
      $display("FAIL por_hold_edge10: reset=%b expected 1", reset);
    end
    cyc(1);
    n_checks++;
    if (reset !== 1'b0 || rst_cause !== 2'd0 || rst_count !== 8'd0) begin
      n_fail++;
      $display("FAIL por_release_edge11: reset=%b cause=%0d count=%0d, expected 0 0 0",
               reset, rst_cause, rst_count);
    end
    $display("txn por_release: reset=%b cause=%0d count=%0d", reset, rst_cause, rst_count);
  endtask

  // 3-cycle glitch must never reach btn_db or reset.
  task automatic test_glitch();
    cyc(3);
    btn_n = 1'b0;
    cyc(3);
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_checks++;
      if (btn_db !== 1'b0 || reset !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_cycle%0d: btn_db=%b reset=%b, expected 0 0", i, btn_db, reset);
      end
    end
    n_checks++;
    if (rst_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL glitch_count: count=%0d expected %0d", rst_count, exp_count);
    end
    $display("txn glitch: btn_db=%b reset=%b count=%0d", btn_db, reset, rst_count);
  endtask

  // 20-cycle press: btn_db at +6, reset at +7, reset falls 8 after btn_db drops.
  task automatic test_long_press();
    cyc(3);
    btn_n = 1'b0;
    cyc(5);
    n_checks++;
    if (btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL lp_db_early: btn_db=%b expected 0", btn_db);
    end
    cyc(1);
    n_checks++;
    if (btn_db !== 1'b1 || reset !== 1'b0) begin
      n_fail++;
      $display("FAIL lp_db_rise: btn_db=%b reset=%b, expected 1 0", btn_db, reset);
    end
    cyc(1);
    exp_count++;
    n_checks++;
    if (reset !== 1'b1 || rst_cause !== 2'd2 || rst_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL lp_reset_rise: reset=%b cause=%0d count=%0d, expected 1 2 %0d",
               reset, rst_cause, rst_count, exp_count);
    end
    cyc(13);
    btn_n = 1'b1;
    cyc(5);
    n_checks++;
    if (btn_db !== 1'b1) begin
      n_fail++;
      $display("FAIL lp_db_hold: btn_db=%b expected 1", btn_db);
    end
    cyc(1);
    n_checks++;
    if (btn_db !== 1'b0 || reset !== 1'b1) begin
      n_fail++;
      $display("FAIL lp_db_fall: btn_db=%b reset=%b, expected 0 1", btn_db, reset);
    end
    cyc(7);
    n_checks++;
    if (reset !== 1'b1) begin
      n_fail++;
      $display("FAIL lp_hold7: reset=%b expected 1", reset);
    end
    cyc(1);
    n_checks++;
    if (reset !== 1'b0) begin
      n_fail++;
      $display("FAIL lp_release8: reset=%b expected 0", reset);
    end
    $display("txn long_press: cause=%0d count=%0d reset=%b", rst_cause, rst_count, reset);
  endtask

  // Lock loss seen in the same cycle as the press pulse: LOCK wins, one count.
  task automatic test_lock_and_press();
    cyc(3);
    btn_n = 1'b0;
    cyc(4);
    locked = 1'b0;
    btn_n  = 1'b1;
    cyc(2);
    n_checks++;
    if (btn_db !== 1'b1 || reset !== 1'b0) begin
      n_fail++;
      $display("FAIL lk_db_rise: btn_db=%b reset=%b, expected 1 0", btn_db, reset);
    end
    cyc(1);
    exp_count++;
    n_checks++;
    if (reset !== 1'b1 || rst_cause !== 2'd1 || rst_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL lk_reset_rise: reset=%b cause=%0d count=%0d, expected 1 1 %0d",
               reset, rst_cause, rst_count, exp_count);
    end
    cyc(2);
    locked = 1'b1;
    cyc(1);
    n_checks++;
    if (btn_db !== 1'b0 || rst_cause !== 2'd1 || rst_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL lk_single_count: btn_db=%b cause=%0d count=%0d, expected 0 1 %0d",
               btn_db, rst_cause, rst_count, exp_count);
    end
    cyc(9);
    n_checks++;
    if (reset !== 1'b1) begin
      n_fail++;
      $display("FAIL lk_hold_edge10: reset=%b expected 1", reset);
    end
    cyc(1);
    n_checks++;
    if (reset !== 1'b0 || rst_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL lk_release_edge11: reset=%b count=%0d, expected 0 %0d",
               reset, rst_count, exp_count);
    end
    $display("txn lock_and_press: cause=%0d count=%0d reset=%b", rst_cause, rst_count, reset);
  endtask

  // 300 full press/hold/run cycles: counter must stop at 255.
  task automatic test_saturation();
    cyc(3);
    for (int i = 0; i < 300; i++) begin
      btn_n = 1'b0;
      cyc(5);
      btn_n = 1'b1;
      cyc(25);
      exp_count = (exp_count == 255) ? 255 : exp_count + 1;
      n_checks++;
      if (rst_count !== 8'(exp_count) || reset !== 1'b0 || rst_cause !== 2'd2) begin
        n_fail++;
        $display("FAIL sat_press%0d: count=%0d reset=%b cause=%0d, expected %0d 0 2",
                 i, rst_count, reset, rst_cause, exp_count);
      end
    end
    $display("txn saturation: count=%0d", rst_count);
  endtask

  // resetn pulsed mid-HOLD between edges, with the button still held.
  task automatic test_async_reset();
    cyc(3);
    btn_n = 1'b0;
    cyc(10);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (reset !== 1'b1 || rst_count !== 8'd0 || rst_cause !== 2'd0 || btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL async_assert: reset=%b count=%0d cause=%0d btn_db=%b, expected 1 0 0 0",
               reset, rst_count, rst_cause, btn_db);
    end
    exp_count = 0;
    btn_n = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(10);
    n_checks++;
    if (reset !== 1'b1) begin
      n_fail++;
      $display("FAIL async_hold_edge10: reset=%b expected 1", reset);
    end
    cyc(1);
    n_checks++;
    if (reset !== 1'b0 || rst_count !== 8'd0 || rst_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL async_release_edge11: reset=%b count=%0d cause=%0d, expected 0 0 0",
               reset, rst_count, rst_cause);
    end
    $display("txn async_reset: reset=%b count=%0d cause=%0d", reset, rst_count, rst_cause);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    test_reset();
    test_glitch();
    test_long_press();
    test_lock_and_press();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Reset sequencer directly upstream of the SoC core's `reset` input on the MAX1000 board.
- Combines the PLL lock indication and the bouncy, asynchronous, active-low user button into one clean active-high core reset:
  - asserted asynchronously,
  - released synchronously, only after a minimum hold time.
- Also records the cause of the last reset and a saturating reset counter, so firmware can read them through a status register.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (`btn_n`, `locked`); legal range 2..4.
- DEB_CYCLES, 640000, consecutive stable `clk` cycles needed before the debounced button level changes (20 ms at 32 MHz).
- HOLD_CYCLES, 16, minimum number of `clk` cycles `reset` stays high after every cause clears.
- CNT_W, 8, width of `rst_count`.

Ports:
- clk  in  1  core clock (PLL output).
- resetn  in  1  asynchronous active-low power-on reset.
- btn_n  in  1  raw user button, low = pressed, asynchronous to `clk`.
- locked  in  1  PLL lock, asynchronous to `clk`.
- reset  out  1  active-high core reset; registered output.
- btn_db  out  1  debounced button level, 1 = pressed.
- rst_cause  out  2  cause of the last reset: 0 = POR, 1 = LOCK, 2 = BTN, 3 = reserved.
- rst_count  out  CNT_W  number of resets since POR; saturating.

Behaviour:
- resetn low (asynchronous):
  - `reset` = 1, `btn_db` = 0, `rst_cause` = 0, `rst_count` = 0.
  - Synchronizers: `btn_n` chain preset to 1 (released), `locked` chain cleared to 0.
  - Debounce counter = 0; state = WAIT_LOCK.
- resetn release: everything is registered, so no output changes before the first `clk` edge.
- Synchronizers: plain shift chains of SYNC_STAGES flops; `btn_s` and `lock_s` are the last stage. No logic sits between the stages.
- Debounce:
  - Counter clears in any cycle where `~btn_s` equals `btn_db`.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1 while they still differ, `btn_db` toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes `btn_db`.
  - Latency from a stable pin change to `btn_db` = SYNC_STAGES + DEB_CYCLES cycles.
- `press` = a single-cycle pulse when `btn_db` rises 0→1.
- FSM, with `reset` registered from the next state (`reset` = 1 in every state except RUN):
  - WAIT_LOCK:
    - If `lock_s` = 1, go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - HOLD:
    - If `lock_s` = 0, go to WAIT_LOCK.
    - Else if `btn_db` = 1, reload the hold counter (a held button keeps the core in reset).
    - Else if the counter = 0, go to RUN.
    - Else decrement.
  - RUN (`reset` = 0):
    - If `lock_s` = 0, go to WAIT_LOCK, set cause LOCK, `rst_count`++.
    - Else if `press`, go to HOLD, reload the counter, set cause BTN, `rst_count`++.
- Simultaneous lock loss and press in RUN: LOCK wins; the count increments once.
- `reset` rises exactly 1 cycle after the triggering condition is seen in RUN.
- `reset` falls after exactly HOLD_CYCLES cycles in HOLD with the button released and lock stable.
- `rst_count` saturates at 2^CNT_W-1.
- `rst_cause` and `rst_count` change only on RUN exits; HOLD/WAIT_LOCK transitions leave them unchanged.
- `locked` dropping during HOLD returns the FSM to WAIT_LOCK with no count update; the cause stays as previously set.
- `resetn` asserted at any time restarts the full POR sequence.

Decomposition:
- Shared constants header/package holds:
  - cause encodings: RC_POR = 2'd0, RC_LOCK = 2'd1, RC_BTN = 2'd2;
  - FSM state encodings: WAIT_LOCK, HOLD, RUN.
- One sub-module, `btn_debounce`, containing the synchronizer, the debounce counter and the `btn_db`/`press` outputs; parameters SYNC_STAGES and DEB_CYCLES.
- The `locked` synchronizer and the FSM stay in `reset_seq`.

Test Plan (bench uses DEB_CYCLES=4, HOLD_CYCLES=8, SYNC_STAGES=2):
- POR release with `locked` already 1 → `reset` falls exactly 2 + 1 + 8 cycles after the first clock edge (sync, WAIT_LOCK, HOLD); `rst_cause` = 0, `rst_count` = 0.
- In RUN, `btn_n` low for 3 cycles then high → `btn_db` stays 0, `reset` stays 0, `rst_count` unchanged.
- In RUN, `btn_n` low for 20 cycles then high:
  - `btn_db` rises 6 cycles after the press and `reset` rises 1 cycle later; `rst_cause` = 2, `rst_count` = 1;
  - `reset` falls 8 cycles after `btn_db` returns to 0.
- In RUN, `locked` low for 5 cycles and simultaneously `btn_db` rises:
  - `reset` rises; `rst_cause` = 1 and `rst_count` increments by exactly 1;
  - after `locked` returns, `reset` falls 2 + 1 + 8 cycles later.
- 300 button presses (each with release, full HOLD and return to RUN) → `rst_count` saturates at 255.
- `resetn` pulsed low mid-HOLD, off a clock edge → `reset` = 1 immediately, before the next `clk` edge; `rst_count` = 0, `rst_cause` = 0, `btn_db` = 0.
